// File: rtl/debug_probe_capture.sv
// Debug probe capture: records one selected probe channel into a circular
// buffer from arm until a programmable number of samples after a trigger
// match, then freezes it for readout relative to the oldest stored sample.
//
// Optional build macro DEBUG_PROBE_EDGE_TRIG_EN: trigger on a rising match
// (current sample matches, previous ARMED sample did not) instead of on a
// level match.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | not capturing; buffer and pointers hold
// ARMED | storing every sample, waiting for the trigger match
// POST  | storing post-trigger samples until the post counter expires
// DONE  | capture complete; buffer frozen, readout enabled
module debug_probe_capture #(
    parameter int  PROBE_W = 9,
    parameter int  NUM_CH  = 4,
    parameter int  DEPTH   = 64,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                      clk16x,
    input  logic                      reset_n,
    input  logic [NUM_CH*PROBE_W-1:0] probe_in,
    input  logic [3:0]                ch_sel,
    input  logic [PROBE_W-1:0]        trig_value,
    input  logic [PROBE_W-1:0]        trig_mask,
    input  logic [AW-1:0]             post_count,
    input  logic                      arm,
    input  logic                      abort,
    input  logic                      rd_en,
    input  logic [AW-1:0]             rd_addr,
    output logic [PROBE_W-1:0]        rd_data,
    output logic                      rd_valid,
    output logic [1:0]                state,
    output logic                      triggered,
    output logic                      done,
    output logic [AW-1:0]             trig_pos,
    output logic [AW:0]               fill
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ARMED = 2'b01,
        S_POST  = 2'b10,
        S_DONE  = 2'b11
    } state_e;

    localparam logic [AW:0] FILL_MAX = (AW+1)'(DEPTH);

    state_e             state_q, state_d;
    logic [3:0]         sel_q, sel_d;
    logic [AW-1:0]      post_cfg_q, post_cfg_d;
    logic [AW-1:0]      post_cnt_q, post_cnt_d;
    logic [AW-1:0]      wptr_q, wptr_d;
    logic [AW:0]        fill_q, fill_d;
    logic [AW-1:0]      trig_addr_q, trig_addr_d;
    logic               triggered_q, triggered_d;
    logic [PROBE_W-1:0] rd_data_q;
    logic               rd_valid_q;
    logic               wr_en;

    logic [PROBE_W-1:0] mem_q [DEPTH];

    logic [PROBE_W-1:0] sample;
    logic               match;
    logic               fire;
    logic [AW-1:0]      oldest;
    logic [AW-1:0]      rd_idx;
    logic               rd_ok;

    // Select the latched channel and evaluate the masked trigger compare.
    always_comb begin
        sample = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (sel_q == 4'(k)) sample = probe_in[k*PROBE_W +: PROBE_W];
        end
        match  = ((sample ^ trig_value) & trig_mask) == '0;
        oldest = (fill_q == FILL_MAX) ? wptr_q : '0;
        rd_idx = oldest + rd_addr;
        rd_ok  = (state_q == S_DONE) && ({1'b0, rd_addr} < fill_q);
    end

`ifdef DEBUG_PROBE_EDGE_TRIG_EN
    logic prev_match_q, prev_match_d;

    // Previous ARMED match; preset on arm so the first ARMED sample cannot fire.
    always_ff @(posedge clk16x or negedge reset_n) begin
        if (!reset_n) prev_match_q <= 1'b1;
        else          prev_match_q <= prev_match_d;
    end

    always_comb begin
        prev_match_d = prev_match_q;
        if (!abort && (state_q == S_IDLE || state_q == S_DONE) && arm) prev_match_d = 1'b1;
        else if (!abort && state_q == S_ARMED)                          prev_match_d = match;
        fire = match && !prev_match_q;
    end
`else
    always_comb fire = match;
`endif

    // Next-state and capture control; abort overrides everything, including arm.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        post_cfg_d  = post_cfg_q;
        post_cnt_d  = post_cnt_q;
        wptr_d      = wptr_q;
        fill_d      = fill_q;
        trig_addr_d = trig_addr_q;
        triggered_d = triggered_q;
        wr_en       = 1'b0;
        if (abort) begin
            state_d     = S_IDLE;
            triggered_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (arm) begin
                        state_d     = S_ARMED;
                        sel_d       = (int'(ch_sel) < NUM_CH) ? ch_sel : 4'd0;
                        post_cfg_d  = post_count;
                        fill_d      = '0;
                        wptr_d      = '0;
                        trig_addr_d = '0;
                        triggered_d = 1'b0;
                    end
                end
                S_ARMED, S_POST: begin
                    wr_en  = 1'b1;
                    wptr_d = wptr_q + 1'b1;
                    if (fill_q != FILL_MAX) fill_d = fill_q + 1'b1;
                    if (state_q == S_ARMED) begin
                        if (fire) begin
                            trig_addr_d = wptr_q;
                            triggered_d = 1'b1;
                            post_cnt_d  = post_cfg_q;
                            state_d     = (post_cfg_q == '0) ? S_DONE : S_POST;
                        end
                    end else begin
                        if (post_cnt_q == AW'(1)) state_d = S_DONE;
                        post_cnt_d = post_cnt_q - 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Control registers and registered readout.
    always_ff @(posedge clk16x or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            sel_q       <= '0;
            post_cfg_q  <= '0;
            post_cnt_q  <= '0;
            wptr_q      <= '0;
            fill_q      <= '0;
            trig_addr_q <= '0;
            triggered_q <= 1'b0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            post_cfg_q  <= post_cfg_d;
            post_cnt_q  <= post_cnt_d;
            wptr_q      <= wptr_d;
            fill_q      <= fill_d;
            trig_addr_q <= trig_addr_d;
            triggered_q <= triggered_d;
            rd_valid_q  <= rd_en;
            rd_data_q   <= (rd_en && rd_ok) ? mem_q[rd_idx] : '0;
        end
    end

    // Capture RAM; contents deliberately survive reset.
    always_ff @(posedge clk16x) begin
        if (wr_en) mem_q[wptr_q] <= sample;
    end

    // A post count of at most DEPTH-1 can only wrap back to the trigger slot's
    // neighbour, so when the trigger becomes the oldest sample the modular
    // distance is already 0.
    assign trig_pos  = trig_addr_q - oldest;
    assign state     = state_q;
    assign done      = (state_q == S_DONE);
    assign triggered = triggered_q;
    assign fill      = fill_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;

endmodule

// File: tb/tb_debug_probe_capture.sv
// Directed bench for debug_probe_capture with hand-computed expectations.
module tb_debug_probe_capture;

    localparam int PW = 9;
    localparam int NC = 4;
    localparam int DP = 64;
    localparam int AW = 6;

    logic              clk16x = 1'b0;
    logic              reset_n = 1'b0;
    logic [NC*PW-1:0]  probe_in = '0;
    logic [3:0]        ch_sel = '0;
    logic [PW-1:0]     trig_value = '0;
    logic [PW-1:0]     trig_mask = '0;
    logic [AW-1:0]     post_count = '0;
    logic              arm = 1'b0;
    logic              abort = 1'b0;
    logic              rd_en = 1'b0;
    logic [AW-1:0]     rd_addr = '0;
    logic [PW-1:0]     rd_data;
    logic              rd_valid;
    logic [1:0]        state;
    logic              triggered;
    logic              done;
    logic [AW-1:0]     trig_pos;
    logic [AW:0]       fill;

    int n_checks = 0;
    int n_errors = 0;
    int ramp_val = 0;

    always #5 clk16x = ~clk16x;

    debug_probe_capture #(.PROBE_W(PW), .NUM_CH(NC), .DEPTH(DP)) dut (
        .clk16x(clk16x), .reset_n(reset_n), .probe_in(probe_in),
        .ch_sel(ch_sel), .trig_value(trig_value), .trig_mask(trig_mask),
        .post_count(post_count), .arm(arm), .abort(abort),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .state(state), .triggered(triggered), .done(done),
        .trig_pos(trig_pos), .fill(fill)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk16x);
        #1;
    endtask

    task automatic set_ch(input int k, input logic [PW-1:0] v);
        probe_in[k*PW +: PW] = v;
    endtask

    task automatic do_arm(input logic [3:0] ch, input logic [PW-1:0] val,
                          input logic [PW-1:0] mask, input logic [AW-1:0] post);
        ch_sel = ch; trig_value = val; trig_mask = mask; post_count = post;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        ramp_val = 0;
    endtask

    task automatic ramp_until(input logic [1:0] st, input string tag);
        int n = 0;
        while (state != st && n < 300) begin
            set_ch(2, PW'(ramp_val));
            ramp_val++;
            tick();
            n++;
        end
        check(tag, 32'(state), 32'(st));
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [PW-1:0] exp, input string tag);
        rd_en = 1'b1; rd_addr = a;
        tick();
        rd_en = 1'b0;
        check({tag, "_valid"}, 32'(rd_valid), 32'd1);
        check(tag, 32'(rd_data), 32'(exp));
    endtask

    initial begin
        // Reset state
        tick(); tick();
        check("rst_state", 32'(state), 32'd0);
        check("rst_fill", 32'(fill), 32'd0);
        check("rst_trig", 32'(triggered), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rdv", 32'(rd_valid), 32'd0);
        #3 reset_n = 1'b1;
        tick();
        rd(6'd0, 9'h000, "idle_rd");

        // Ramp on channel 2, trigger 0x014, five post samples
        do_arm(4'd2, 9'h014, 9'h1FF, 6'd5);
        check("arm_state", 32'(state), 32'd1);
        ramp_until(2'b11, "r30_done");
        check("r30_fill", 32'(fill), 32'd26);
        check("r30_tpos", 32'(trig_pos), 32'd20);
        check("r30_trig", 32'(triggered), 32'd1);
        check("r30_doneo", 32'(done), 32'd1);
        rd(6'd20, 9'h014, "r30_rd20");
        rd(6'd25, 9'h019, "r30_rd25");
        rd(6'd26, 9'h000, "r30_rd_past_fill");
        tick();
        check("rdv_drop", 32'(rd_valid), 32'd0);

        // Wrapped buffer: 211 samples into 64 slots, oldest is 0x093
        do_arm(4'd2, 9'h0C8, 9'h1FF, 6'd10);
        ramp_until(2'b11, "r31_done");
        check("r31_fill", 32'(fill), 32'd64);
        check("r31_tpos", 32'(trig_pos), 32'd53);
        rd(6'd0, 9'h093, "r31_rd0");
        rd(6'd53, 9'h0C8, "r31_rd53");
        rd(6'd63, 9'h0D2, "r31_rd63");

        // Maximum post count: trigger sample ends up as the oldest
        do_arm(4'd2, 9'h003, 9'h1FF, 6'd63);
        ramp_until(2'b11, "pmax_done");
        check("pmax_fill", 32'(fill), 32'd64);
        check("pmax_tpos", 32'(trig_pos), 32'd0);
        rd(6'd0, 9'h003, "pmax_rd0");
        rd(6'd63, 9'h042, "pmax_rd63");

        // Zero mask, zero post count: DONE two cycles after arm
        set_ch(2, 9'h0AB);
        do_arm(4'd2, 9'h155, 9'h000, 6'd0);
        check("r32_armed", 32'(state), 32'd1);
        tick();
        check("r32_done", 32'(state), 32'd3);
        check("r32_fill", 32'(fill), 32'd1);
        check("r32_tpos", 32'(trig_pos), 32'd0);
        rd(6'd0, 9'h0AB, "r32_rd0");

        // Out-of-range channel select falls back to channel 0
        set_ch(0, 9'h000); set_ch(2, 9'h1A5);
        do_arm(4'd7, 9'h1A5, 9'h1FF, 6'd1);
        tick();
        check("sel_armed", 32'(state), 32'd1);
        set_ch(0, 9'h1A5); tick();
        check("sel_post", 32'(state), 32'd2);
        set_ch(0, 9'h033); tick();
        check("sel_done", 32'(state), 32'd3);
        check("sel_fill", 32'(fill), 32'd3);
        rd(6'd1, 9'h1A5, "sel_rd1");
        rd(6'd2, 9'h033, "sel_rd2");

        // Arm and abort together from DONE: abort wins, data kept
        arm = 1'b1; abort = 1'b1;
        tick();
        arm = 1'b0; abort = 1'b0;
        check("aa_state", 32'(state), 32'd0);
        check("aa_fill", 32'(fill), 32'd3);

        // Abort during POST
        do_arm(4'd2, 9'h005, 9'h1FF, 6'd20);
        ramp_until(2'b10, "ab_post");
        check("ab_fill6", 32'(fill), 32'd6);
        set_ch(2, 9'h006); tick();
        set_ch(2, 9'h007); tick();
        check("ab_trig1", 32'(triggered), 32'd1);
        abort = 1'b1; set_ch(2, 9'h008);
        tick();
        abort = 1'b0;
        check("ab_state", 32'(state), 32'd0);
        check("ab_trig0", 32'(triggered), 32'd0);
        check("ab_fill", 32'(fill), 32'd8);
        tick(); tick(); tick();
        check("ab_nowrite", 32'(fill), 32'd8);
        rd(6'd0, 9'h000, "ab_idle_rd");

        // Arm ignored while capturing
        do_arm(4'd2, 9'h1FF, 9'h1FF, 6'd3);
        set_ch(2, 9'h001); tick();
        set_ch(2, 9'h002); arm = 1'b1; tick(); arm = 1'b0;
        check("rearm_fill", 32'(fill), 32'd2);
        check("rearm_state", 32'(state), 32'd1);

        // Trigger held at value from arm
        abort = 1'b1; tick(); abort = 1'b0;
        set_ch(2, 9'h014);
        do_arm(4'd2, 9'h014, 9'h1FF, 6'd0);
        tick(); tick(); tick();
`ifdef DEBUG_PROBE_EDGE_TRIG_EN
        check("edge_hold", 32'(state), 32'd1);
        set_ch(2, 9'h000); tick();
        check("edge_leave", 32'(state), 32'd1);
        set_ch(2, 9'h014); tick();
        check("edge_done", 32'(state), 32'd3);
        check("edge_fill", 32'(fill), 32'd5);
        check("edge_tpos", 32'(trig_pos), 32'd4);
`else
        check("lvl_done", 32'(state), 32'd3);
        check("lvl_fill", 32'(fill), 32'd1);
        check("lvl_tpos", 32'(trig_pos), 32'd0);
`endif

        // Reset pulse during POST
        do_arm(4'd2, 9'h004, 9'h1FF, 6'd30);
        ramp_until(2'b10, "rp_post");
        rd_en = 1'b1; rd_addr = 6'd0;
        tick();
        rd_en = 1'b0;
        #2 reset_n = 1'b0;
        #2;
        check("rp_state", 32'(state), 32'd0);
        check("rp_fill", 32'(fill), 32'd0);
        check("rp_trig", 32'(triggered), 32'd0);
        check("rp_done", 32'(done), 32'd0);
        check("rp_tpos", 32'(trig_pos), 32'd0);
        check("rp_rdv", 32'(rd_valid), 32'd0);
        check("rp_rdd", 32'(rd_data), 32'd0);
        reset_n = 1'b1;
        tick(); tick();
        check("rp_nowrite", 32'(fill), 32'd0);
        rd(6'd0, 9'h000, "rp_rd");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
